// File: rtl/tq_pkg.sv
// Shared definitions for the transform row datapath: coefficient geometry,
// TU size encoding, row-arbiter FSM states and the rows-per-TU helper.
package tq_pkg;

    localparam int TQ_COEF_W = 28;
    localparam int TQ_NCOEF  = 32;

    // TU size encoding as carried on the size ports.
    typedef enum logic [1:0] {
        SZ4  = 2'd0,
        SZ8  = 2'd1,
        SZ16 = 2'd2,
        SZ32 = 2'd3
    } tq_size_e;

    // Row arbiter ownership FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tq_state_e;

    // Number of rows in a TU of the given size (4, 8, 16 or 32).
    function automatic logic [5:0] tq_rows(input tq_size_e size);
        tq_rows = 6'd4 << size;
    endfunction

endpackage

// File: rtl/tq_arb2.sv
// Two-way grant function for the row arbiter.
// Macro TQ_ROW_ARB_RR_EN: when defined, ties are broken round-robin using a
// pointer that remembers the most recent TU winner; otherwise requester 0
// always wins a tie.
module tq_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

`ifdef TQ_ROW_ARB_RR_EN
    logic last_r;

    // One-hot grant; on a tie the requester that did not win last time goes.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (last_r) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of each TU grant; reset so requester 0 wins first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_r <= 1'b1;
        end else if (upd) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = &{1'b0, clk, rstn, upd};

    // One-hot fixed-priority grant, requester 0 first.
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/tq_row_arb.sv
// Two-way row arbiter for the shared 1-D transform row datapath. Ownership is
// locked for a whole TU (4/8/16/32 rows); the granted row is forwarded through
// a single output register with source, size and framing tags.
// Macro TQ_ROW_ARB_RR_EN selects round-robin tie-breaking (default: fixed
// priority, requester 0 first).
module tq_row_arb
    import tq_pkg::*;
#(
    parameter int COEF_W = TQ_COEF_W,
    parameter int NCOEF  = TQ_NCOEF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_0_valid,
    input  logic [1:0]                i_0_size,
    input  logic [NCOEF*COEF_W-1:0]   i_0_data,
    output logic                      o_0_ready,
    input  logic                      i_1_valid,
    input  logic [1:0]                i_1_size,
    input  logic [NCOEF*COEF_W-1:0]   i_1_data,
    output logic                      o_1_ready,
    output logic                      o_valid,
    output logic                      o_src,
    output logic [1:0]                o_size,
    output logic                      o_first,
    output logic                      o_last,
    output logic [NCOEF*COEF_W-1:0]   o_data
);

    tq_state_e                 state_r;
    logic                      own_r;
    tq_size_e                  size_r;
    logic [4:0]                cnt_r;

    logic [1:0]                gnt_s;
    logic                      ready0_s;
    logic                      ready1_s;
    logic                      xfer0_s;
    logic                      xfer1_s;
    logic                      xfer_s;
    logic                      src_s;
    logic                      upd_s;
    logic                      last_row_s;
    tq_size_e                  size_s;
    logic [NCOEF*COEF_W-1:0]   data_s;

    assign upd_s = (state_r == ST_IDLE) && xfer_s;

    tq_arb2 u_arb (
        .clk  (clk),
        .rstn (rstn),
        .req  ({i_1_valid, i_0_valid}),
        .upd  (upd_s),
        .gnt  (gnt_s)
    );

    // Ready: arbitration winner while idle, fixed owner while a TU is open.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready0_s = gnt_s[0];
                ready1_s = gnt_s[1];
            end
            ST_BUSY: begin
                ready0_s = ~own_r;
                ready1_s = own_r;
            end
            default: begin
                ready0_s = 1'b0;
                ready1_s = 1'b0;
            end
        endcase
    end

    // Ready is held low while reset is asserted so no requester sees a grant.
    assign o_0_ready = rstn & ready0_s;
    assign o_1_ready = rstn & ready1_s;
    assign xfer0_s   = o_0_ready & i_0_valid;
    assign xfer1_s   = o_1_ready & i_1_valid;
    assign xfer_s    = xfer0_s | xfer1_s;
    assign src_s     = xfer1_s;

    // Select the transferring row, its TU size (from row 0 only) and detect
    // the final row of the open TU.
    always_comb begin
        data_s     = i_0_data;
        size_s     = size_r;
        last_row_s = 1'b0;
        if (src_s) begin
            data_s = i_1_data;
        end else begin
            data_s = i_0_data;
        end
        if (state_r == ST_IDLE) begin
            if (src_s) begin
                size_s = tq_size_e'(i_1_size);
            end else begin
                size_s = tq_size_e'(i_0_size);
            end
            last_row_s = 1'b0;
        end else begin
            size_s     = size_r;
            last_row_s = ({1'b0, cnt_r} == (tq_rows(size_r) - 6'd1));
        end
    end

    // Ownership FSM, row counter and the registered output row with its tags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            own_r   <= 1'b0;
            size_r  <= SZ4;
            cnt_r   <= 5'd0;
            o_valid <= 1'b0;
            o_src   <= 1'b0;
            o_size  <= 2'd0;
            o_first <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= xfer_s;
            if (xfer_s) begin
                o_data  <= data_s;
                o_src   <= src_s;
                o_size  <= size_s;
                o_first <= (state_r == ST_IDLE);
                o_last  <= last_row_s;
            end else begin
                o_data  <= o_data;
                o_src   <= o_src;
                o_size  <= o_size;
                o_first <= o_first;
                o_last  <= o_last;
            end

            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        own_r   <= src_s;
                        size_r  <= size_s;
                        cnt_r   <= 5'd1;
                        state_r <= ST_BUSY;
                    end else begin
                        own_r   <= own_r;
                        size_r  <= size_r;
                        cnt_r   <= cnt_r;
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (xfer_s && last_row_s) begin
                        cnt_r   <= 5'd0;
                        state_r <= ST_IDLE;
                    end else if (xfer_s) begin
                        cnt_r   <= cnt_r + 5'd1;
                        state_r <= ST_BUSY;
                    end else begin
                        cnt_r   <= cnt_r;
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    cnt_r   <= 5'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tq_row_arb.sv
// Directed self-checking bench for tq_row_arb.
module tb_tq_row_arb;

    logic         clk = 1'b0;
    logic         rstn;
    logic         i_0_valid;
    logic [1:0]   i_0_size;
    logic [895:0] i_0_data;
    logic         o_0_ready;
    logic         i_1_valid;
    logic [1:0]   i_1_size;
    logic [895:0] i_1_data;
    logic         o_1_ready;
    logic         o_valid;
    logic         o_src;
    logic [1:0]   o_size;
    logic         o_first;
    logic         o_last;
    logic [895:0] o_data;

    int runs  = 0;
    int fails = 0;

    tq_row_arb dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_0_valid (i_0_valid),
        .i_0_size  (i_0_size),
        .i_0_data  (i_0_data),
        .o_0_ready (o_0_ready),
        .i_1_valid (i_1_valid),
        .i_1_size  (i_1_size),
        .i_1_data  (i_1_data),
        .o_1_ready (o_1_ready),
        .o_valid   (o_valid),
        .o_src     (o_src),
        .o_size    (o_size),
        .o_first   (o_first),
        .o_last    (o_last),
        .o_data    (o_data)
    );

    always #5 clk = ~clk;

    // Row payload tagged with source, TU id and row index.
    function automatic logic [895:0] mk(input int src, input int tu, input int row);
        logic [31:0] t;
        t = {8'(src), 8'(tu), 16'(row)};
        return {28{t}};
    endfunction

    task automatic idle_inputs();
        i_0_valid = 1'b0; i_0_size = 2'd0; i_0_data = '0;
        i_1_valid = 1'b0; i_1_size = 2'd0; i_1_data = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        runs++;
        if (o_valid !== 1'b0 || o_src !== 1'b0 || o_size !== 2'd0 || o_first !== 1'b0 ||
            o_last !== 1'b0 || o_data !== 896'd0 || o_0_ready !== 1'b0 || o_1_ready !== 1'b0) begin
            $display("FAIL reset_outputs: valid=%b src=%b size=%0d first=%b last=%b data_lo=%h rdy=%b%b, required all 0",
                     o_valid, o_src, o_size, o_first, o_last, o_data[31:0], o_1_ready, o_0_ready);
            fails++;
        end
        rstn = 1'b1;
        @(negedge clk);
        runs++;
        if (o_valid !== 1'b0 || o_0_ready !== 1'b0 || o_1_ready !== 1'b0) begin
            $display("FAIL reset_idle: valid=%b rdy=%b%b, required 0 00", o_valid, o_1_ready, o_0_ready);
            fails++;
        end
    endtask

    task automatic test_single();
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            i_0_valid = 1'b1; i_0_size = 2'd1; i_0_data = mk(0, 1, r);
            #1;
            runs++;
            if (o_0_ready !== 1'b1 || o_1_ready !== 1'b0) begin
                $display("FAIL single_ready row %0d: rdy1=%b rdy0=%b, required 0 1", r, o_1_ready, o_0_ready);
                fails++;
            end
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b0 || o_size !== 2'd1 || o_first !== (r == 0) ||
                o_last !== (r == 7) || o_data !== mk(0, 1, r)) begin
                $display("FAIL single_out row %0d: v=%b src=%b size=%0d first=%b last=%b data_lo=%h, required 1 0 1 %b %b %h",
                         r, o_valid, o_src, o_size, o_first, o_last, o_data[31:0], (r == 0), (r == 7), mk(0, 1, r) & 896'hffffffff);
                fails++;
            end
        end
        @(negedge clk);
        i_0_valid = 1'b0;
        #1;
        runs++;
        if (o_0_ready !== 1'b0) begin
            $display("FAIL single_idle_ready: rdy0=%b, required 0", o_0_ready);
            fails++;
        end
        @(posedge clk); #1;
        runs++;
        if (o_valid !== 1'b0 || o_data !== mk(0, 1, 7) || o_last !== 1'b1) begin
            $display("FAIL single_hold: v=%b last=%b data_lo=%h, required 0 1 %h", o_valid, o_last, o_data[31:0], 32'h00010007);
            fails++;
        end
    endtask

    task automatic test_lock();
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            i_1_valid = 1'b1; i_1_size = 2'd3; i_1_data = mk(1, 3, r);
            i_0_valid = (r >= 5); i_0_size = 2'd0; i_0_data = mk(0, 4, 0);
            #1;
            runs++;
            if (o_0_ready !== 1'b0 || o_1_ready !== 1'b1) begin
                $display("FAIL lock_ready row %0d: rdy1=%b rdy0=%b, required 1 0", r, o_1_ready, o_0_ready);
                fails++;
            end
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b1 || o_size !== 2'd3 || o_first !== (r == 0) ||
                o_last !== (r == 31) || o_data !== mk(1, 3, r)) begin
                $display("FAIL lock_out row %0d: v=%b src=%b size=%0d first=%b last=%b data_lo=%h, required 1 1 3 %b %b",
                         r, o_valid, o_src, o_size, o_first, o_last, o_data[31:0], (r == 0), (r == 31));
                fails++;
            end
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            i_1_valid = 1'b0;
            i_0_valid = 1'b1; i_0_size = 2'd0; i_0_data = mk(0, 4, r);
            #1;
            runs++;
            if (o_0_ready !== 1'b1 || o_1_ready !== 1'b0) begin
                $display("FAIL lock_next_ready row %0d: rdy1=%b rdy0=%b, required 0 1", r, o_1_ready, o_0_ready);
                fails++;
            end
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b0 || o_size !== 2'd0 || o_first !== (r == 0) ||
                o_last !== (r == 3) || o_data !== mk(0, 4, r)) begin
                $display("FAIL lock_next_out row %0d: v=%b src=%b size=%0d first=%b last=%b, required 1 0 0 %b %b",
                         r, o_valid, o_src, o_size, o_first, o_last, (r == 0), (r == 3));
                fails++;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_tie();
        int pend[2];
        int tu[2];
        int w;
        int last_tb;
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        pend[0] = 2; pend[1] = 2;
        tu[0] = 0; tu[1] = 0;
        last_tb = 1;
        for (int t = 0; t < 4; t++) begin
            if (pend[0] > 0 && pend[1] > 0) begin
`ifdef TQ_ROW_ARB_RR_EN
                w = (last_tb == 1) ? 0 : 1;
`else
                w = 0;
`endif
            end else begin
                w = (pend[0] > 0) ? 0 : 1;
            end
            for (int r = 0; r < 4; r++) begin
                @(negedge clk);
                i_0_valid = (pend[0] > 0); i_0_size = 2'd0; i_0_data = mk(0, 10 + tu[0], (w == 0) ? r : 0);
                i_1_valid = (pend[1] > 0); i_1_size = 2'd0; i_1_data = mk(1, 10 + tu[1], (w == 1) ? r : 0);
                #1;
                runs++;
                if (o_0_ready !== (w == 0) || o_1_ready !== (w == 1)) begin
                    $display("FAIL tie_ready tu %0d row %0d: rdy1=%b rdy0=%b, required winner %0d", t, r, o_1_ready, o_0_ready, w);
                    fails++;
                end
                @(posedge clk); #1;
                runs++;
                if (o_valid !== 1'b1 || o_src !== w[0] || o_first !== (r == 0) || o_last !== (r == 3) ||
                    o_data !== mk(w, 10 + tu[w], r)) begin
                    $display("FAIL tie_out tu %0d row %0d: v=%b src=%b first=%b last=%b data_lo=%h, required 1 %0d %b %b",
                             t, r, o_valid, o_src, o_first, o_last, o_data[31:0], w, (r == 0), (r == 3));
                    fails++;
                end
            end
            pend[w] = pend[w] - 1;
            tu[w]   = tu[w] + 1;
            last_tb = w;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_stall();
        int acc;
        logic v;
        acc = 0;
        for (int c = 0; c < 19; c++) begin
            v = !(c >= 7 && c <= 9);
            @(negedge clk);
            i_0_valid = v; i_0_size = 2'd2; i_0_data = mk(0, 5, acc);
            #1;
            runs++;
            if (o_0_ready !== 1'b1 || o_1_ready !== 1'b0) begin
                $display("FAIL stall_ready cycle %0d: rdy1=%b rdy0=%b, required 0 1", c, o_1_ready, o_0_ready);
                fails++;
            end
            @(posedge clk); #1;
            runs++;
            if (v) begin
                if (o_valid !== 1'b1 || o_first !== (acc == 0) || o_last !== (acc == 15) ||
                    o_size !== 2'd2 || o_data !== mk(0, 5, acc)) begin
                    $display("FAIL stall_out row %0d: v=%b first=%b last=%b size=%0d data_lo=%h, required 1 %b %b 2",
                             acc, o_valid, o_first, o_last, o_size, o_data[31:0], (acc == 0), (acc == 15));
                    fails++;
                end
                acc++;
            end else begin
                if (o_valid !== 1'b0 || o_data !== mk(0, 5, acc - 1)) begin
                    $display("FAIL stall_gap cycle %0d: v=%b data_lo=%h, required 0 and held row %0d", c, o_valid, o_data[31:0], acc - 1);
                    fails++;
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        runs++;
        if (o_0_ready !== 1'b0) begin
            $display("FAIL stall_end_idle: rdy0=%b, required 0", o_0_ready);
            fails++;
        end
    endtask

    task automatic test_size_change();
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            i_1_valid = 1'b1; i_1_size = (r == 0) ? 2'd3 : 2'd0; i_1_data = mk(1, 6, r);
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b1 || o_size !== 2'd3 || o_first !== (r == 0) ||
                o_last !== (r == 31) || o_data !== mk(1, 6, r)) begin
                $display("FAIL size_change row %0d: v=%b src=%b size=%0d first=%b last=%b, required 1 1 3 %b %b",
                         r, o_valid, o_src, o_size, o_first, o_last, (r == 0), (r == 31));
                fails++;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        runs++;
        if (o_1_ready !== 1'b0) begin
            $display("FAIL size_change_end: rdy1=%b, required 0", o_1_ready);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            i_1_valid = 1'b1; i_1_size = 2'd3; i_1_data = mk(1, 7, r);
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b1 || o_data !== mk(1, 7, r)) begin
                $display("FAIL rmid_pre row %0d: v=%b src=%b data_lo=%h, required 1 1", r, o_valid, o_src, o_data[31:0]);
                fails++;
            end
        end
        @(negedge clk);
        i_1_data = mk(1, 7, 10);
        rstn = 1'b0;
        #1;
        runs++;
        if (o_valid !== 1'b0 || o_src !== 1'b0 || o_size !== 2'd0 || o_first !== 1'b0 ||
            o_last !== 1'b0 || o_data !== 896'd0 || o_0_ready !== 1'b0 || o_1_ready !== 1'b0) begin
            $display("FAIL rmid_reset: v=%b src=%b size=%0d first=%b last=%b data_lo=%h rdy=%b%b, required all 0",
                     o_valid, o_src, o_size, o_first, o_last, o_data[31:0], o_1_ready, o_0_ready);
            fails++;
        end
        @(posedge clk); #1;
        runs++;
        if (o_valid !== 1'b0) begin
            $display("FAIL rmid_reset_hold: v=%b, required 0", o_valid);
            fails++;
        end
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            rstn = 1'b1;
            i_1_valid = 1'b1; i_1_size = 2'd1; i_1_data = mk(1, 8, r);
            #1;
            runs++;
            if (o_1_ready !== 1'b1) begin
                $display("FAIL rmid_new_ready row %0d: rdy1=%b, required 1", r, o_1_ready);
                fails++;
            end
            @(posedge clk); #1;
            runs++;
            if (o_valid !== 1'b1 || o_src !== 1'b1 || o_size !== 2'd1 || o_first !== (r == 0) ||
                o_last !== (r == 7) || o_data !== mk(1, 8, r)) begin
                $display("FAIL rmid_new_out row %0d: v=%b src=%b size=%0d first=%b last=%b, required 1 1 1 %b %b",
                         r, o_valid, o_src, o_size, o_first, o_last, (r == 0), (r == 7));
                fails++;
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_lock();
        test_tie();
        test_stall();
        test_size_change();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule
